// File: rtl/branch_resolve.sv
// Branch resolution: tracks predictor tags through the ID/EX slots, detects mispredicts and emits predictor updates.
// Define BR_STATS_EN to add saturating resolved-branch and mispredict counters (br_count, miss_count).
module branch_resolve (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic [2:0]  pred_index,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        upd_en,
    output logic [2:0]  upd_index,
    output logic        upd_taken,
    output logic [31:0] upd_target
`ifdef BR_STATS_EN
    ,
    output logic [15:0] br_count,
    output logic [15:0] miss_count
`endif
);

    logic        r_id_valid, r_ex_valid;
    logic [31:0] r_id_pc, r_ex_pc;
    logic        r_id_pt, r_ex_pt;
    logic [31:0] r_id_ptg, r_ex_ptg;
    logic [2:0]  r_id_idx, r_ex_idx;

    logic        w_act_taken;
    logic        w_mispredict;

    // Stall wins over flush; flush and stall are mutually exclusive by construction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_pt    <= 1'b0;
            r_id_ptg   <= '0;
            r_id_idx   <= '0;
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_pt    <= 1'b0;
            r_ex_ptg   <= '0;
            r_ex_idx   <= '0;
        end else if (!stall) begin
            if (flush) begin
                r_id_valid <= 1'b0;
                r_ex_valid <= 1'b0;
            end else begin
                r_id_valid <= if_valid;
                r_id_pc    <= if_pc;
                r_id_pt    <= pred_taken;
                r_id_ptg   <= pred_target;
                r_id_idx   <= pred_index;
                r_ex_valid <= r_id_valid;
                r_ex_pc    <= r_id_pc;
                r_ex_pt    <= r_id_pt;
                r_ex_ptg   <= r_id_ptg;
                r_ex_idx   <= r_id_idx;
            end
        end
    end

    always_comb begin
        w_act_taken  = ex_is_branch & ex_taken;
        w_mispredict = r_ex_valid &
                       ((ex_is_branch & (ex_taken != r_ex_pt)) |
                        (w_act_taken & r_ex_pt & (ex_target != r_ex_ptg)) |
                        (!ex_is_branch & r_ex_pt));
        flush        = w_mispredict & !stall;
        redirect_pc  = (r_ex_valid & w_act_taken) ? ex_target : r_ex_pc + 32'd4;
        upd_en       = r_ex_valid & ex_is_branch & !stall;
        // Update fields read as zero while EX is empty so idle/reset outputs are quiet.
        upd_index    = r_ex_valid ? r_ex_idx : '0;
        upd_taken    = r_ex_valid & ex_taken;
        upd_target   = r_ex_valid ? ex_target : '0;
    end

`ifdef BR_STATS_EN
    logic [15:0] r_br_count, r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            if (upd_en && (r_br_count != '1))
                r_br_count <= r_br_count + 16'd1;
            if (upd_en && flush && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, stall/reset sequences, and random traffic vs a next-PC model.
// With BR_STATS_EN defined, the statistics counters are checked as well.
module tb_branch_resolve;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        stall, if_valid, pred_taken, ex_is_branch, ex_taken;
    logic [31:0] if_pc, pred_target, ex_target;
    logic [2:0]  pred_index;
    logic        flush, upd_en, upd_taken;
    logic [31:0] redirect_pc, upd_target;
    logic [2:0]  upd_index;
`ifdef BR_STATS_EN
    logic [15:0] br_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    branch_resolve dut (
        .CLK(CLK), .nRST(nRST), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush(flush), .redirect_pc(redirect_pc), .upd_en(upd_en), .upd_index(upd_index),
        .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BR_STATS_EN
        , .br_count(br_count), .miss_count(miss_count)
`endif
    );

    typedef struct packed {
        logic        stall;
        logic        ifv;
        logic [31:0] ifpc;
        logic        pt;
        logic [31:0] ptg;
        logic [2:0]  pidx;
        logic        exb;
        logic        ext;
        logic [31:0] extg;
        logic        e_flush;
        logic [31:0] e_rpc;
        logic        e_upd;
        logic        e_taken;
        logic [2:0]  e_idx;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic [2:0]  idx;
    } tag_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic st, input logic ifv, input logic [31:0] ifpc,
                                input logic pt, input logic [31:0] ptg, input logic [2:0] pidx,
                                input logic exb, input logic ext, input logic [31:0] extg,
                                input logic ef, input logic [31:0] erpc, input logic eu,
                                input logic etk, input logic [2:0] eidx);
        vec_t v;
        v = '{st, ifv, ifpc, pt, ptg, pidx, exb, ext, extg, ef, erpc, eu, etk, eidx};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; if_valid = v.ifv; if_pc = v.ifpc; pred_taken = v.pt;
        pred_target = v.ptg; pred_index = v.pidx; ex_is_branch = v.exb;
        ex_taken = v.ext; ex_target = v.extg;
    endtask

    task automatic zero_inputs();
        stall = 0; if_valid = 0; if_pc = '0; pred_taken = 0; pred_target = '0;
        pred_index = '0; ex_is_branch = 0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".flush"}, {31'd0, flush}, 32'd0);
        check({tag, ".upd_en"}, {31'd0, upd_en}, 32'd0);
        check({tag, ".redirect_pc"}, redirect_pc, 32'h4);
        check({tag, ".upd_index"}, {29'd0, upd_index}, 32'd0);
        check({tag, ".upd_taken"}, {31'd0, upd_taken}, 32'd0);
        check({tag, ".upd_target"}, upd_target, 32'd0);
    endtask

    // Leaves time at posedge+1 with both slots empty.
    task automatic do_reset();
        nRST = 0;
        zero_inputs();
        @(posedge CLK); #1;
        check_idle("reset");
        @(negedge CLK); nRST = 1;
        @(posedge CLK); #1;
    endtask

    tag_t m_id, m_ex;
    logic act_tk, e_miss, e_flush, e_upd;
    logic [31:0] e_rpc;
    logic [31:0] tgts[4];

    initial begin
        tgts[0] = 32'h1000; tgts[1] = 32'h2000; tgts[2] = 32'h3000; tgts[3] = 32'hFFFF_FFFC;

        vecs[0]  = mk(0,1,32'h100,0,32'h0,  3'd5, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[1]  = mk(0,1,32'h104,1,32'h300,3'd3, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[2]  = mk(0,1,32'h108,1,32'h400,3'd1, 1,1,32'h200, 1,32'h200,1,1,3'd5);
        vecs[3]  = mk(0,1,32'h104,1,32'h300,3'd3, 1,1,32'h999, 0,32'h0,  0,0,3'd0);
        vecs[4]  = mk(0,1,32'h200,0,32'h0,  3'd0, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[5]  = mk(0,1,32'h108,1,32'h400,3'd1, 1,0,32'h0,   1,32'h108,1,0,3'd3);
        vecs[6]  = mk(0,1,32'h108,1,32'h400,3'd1, 1,1,32'h404, 0,32'h0,  0,0,3'd0);
        vecs[7]  = mk(0,1,32'h10C,1,32'h400,3'd2, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[8]  = mk(0,1,32'h110,0,32'h0,  3'd0, 1,1,32'h404, 1,32'h404,1,1,3'd1);
        vecs[9]  = mk(0,1,32'h404,1,32'h400,3'd2, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[10] = mk(0,1,32'h408,0,32'h0,  3'd0, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[11] = mk(0,1,32'h20, 1,32'h50, 3'd6, 1,1,32'h400, 0,32'h0,  1,1,3'd2);
        vecs[12] = mk(0,1,32'h24, 0,32'h0,  3'd0, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[13] = mk(0,1,32'h28, 0,32'h0,  3'd0, 0,0,32'h0,   1,32'h24, 0,0,3'd0);
        vecs[14] = mk(0,1,32'h500,0,32'h0,  3'd7, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[15] = mk(0,1,32'h504,0,32'h0,  3'd0, 0,0,32'h0,   0,32'h0,  0,0,3'd0);
        vecs[16] = mk(1,1,32'h508,0,32'h0,  3'd0, 1,1,32'h600, 0,32'h0,  0,0,3'd0);
        vecs[17] = mk(1,1,32'h508,0,32'h0,  3'd0, 1,1,32'h600, 0,32'h0,  0,0,3'd0);
        vecs[18] = mk(1,1,32'h508,0,32'h0,  3'd0, 1,1,32'h600, 0,32'h0,  0,0,3'd0);
        vecs[19] = mk(0,1,32'h508,0,32'h0,  3'd0, 1,1,32'h600, 1,32'h600,1,1,3'd7);
        vecs[20] = mk(0,1,32'h50C,0,32'h0,  3'd0, 1,1,32'h600, 0,32'h0,  0,0,3'd0);

        zero_inputs();
        #2;
        check_idle("async_reset");
        do_reset();
        check_idle("post_reset");

        // Directed table: one row per cycle, outputs checked mid-cycle.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("vec%0d.flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
            check($sformatf("vec%0d.upd_en", i), {31'd0, upd_en}, {31'd0, vecs[i].e_upd});
            if (vecs[i].e_flush)
                check($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            if (vecs[i].e_upd) begin
                check($sformatf("vec%0d.upd_taken", i), {31'd0, upd_taken}, {31'd0, vecs[i].e_taken});
                check($sformatf("vec%0d.upd_index", i), {29'd0, upd_index}, {29'd0, vecs[i].e_idx});
                check($sformatf("vec%0d.upd_target", i), upd_target, vecs[i].extg);
            end
            @(posedge CLK); #1;
        end

        // Reset while a mispredicting branch sits in EX: no flush or update may survive.
        zero_inputs();
        if_valid = 1; if_pc = 32'h700; pred_index = 3'd4;
        repeat (2) begin @(posedge CLK); #1; end
        ex_is_branch = 1; ex_taken = 1; ex_target = 32'h800;
        #1;
        check("midrst.pre_flush", {31'd0, flush}, 32'd1);
        nRST = 0;
        #1;
        check_idle("midrst.during");
        @(negedge CLK); nRST = 1;
        @(posedge CLK); #1;
        check("midrst.after.flush", {31'd0, flush}, 32'd0);
        check("midrst.after.upd_en", {31'd0, upd_en}, 32'd0);

        // Random traffic against a next-PC style reference.
        do_reset();
        m_id = '{0, '0, 0, '0, '0};
        m_ex = '{0, '0, 0, '0, '0};
        for (int c = 0; c < 3000; c++) begin
            stall        = ($urandom_range(0, 3) == 0);
            if_valid     = ($urandom_range(0, 3) != 0);
            if_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            pred_taken   = $urandom_range(0, 1);
            pred_target  = tgts[$urandom_range(0, 3)];
            pred_index   = 3'($urandom_range(0, 7));
            ex_is_branch = $urandom_range(0, 1);
            ex_taken     = $urandom_range(0, 1);
            ex_target    = tgts[$urandom_range(0, 3)];
            #3;
            act_tk  = ex_is_branch & ex_taken;
            e_miss  = m_ex.v && ((m_ex.pt != act_tk) || (act_tk && (m_ex.ptg != ex_target)));
            e_flush = e_miss && !stall;
            e_upd   = m_ex.v && ex_is_branch && !stall;
            e_rpc   = act_tk ? ex_target : m_ex.pc + 32'd4;
            check("rnd.flush", {31'd0, flush}, {31'd0, e_flush});
            check("rnd.upd_en", {31'd0, upd_en}, {31'd0, e_upd});
            if (e_flush) check("rnd.redirect_pc", redirect_pc, e_rpc);
            if (e_upd) begin
                check("rnd.upd_taken", {31'd0, upd_taken}, {31'd0, ex_taken});
                check("rnd.upd_index", {29'd0, upd_index}, {29'd0, m_ex.idx});
                check("rnd.upd_target", upd_target, ex_target);
            end
            if (!stall) begin
                if (e_flush) begin
                    m_id.v = 0;
                    m_ex.v = 0;
                end else begin
                    m_ex = m_id;
                    m_id = '{if_valid, if_pc, pred_taken, pred_target, pred_index};
                end
            end
            @(posedge CLK); #1;
        end

`ifdef BR_STATS_EN
        do_reset();
        check("stats.reset.br", {16'd0, br_count}, 32'd0);
        check("stats.reset.miss", {16'd0, miss_count}, 32'd0);
        zero_inputs();
        if_valid = 1; ex_is_branch = 1;
        repeat (10) @(posedge CLK);
        #1;
        check("stats.correct.br", {16'd0, br_count}, 32'd8);
        check("stats.correct.miss", {16'd0, miss_count}, 32'd0);
        ex_taken = 1;
        repeat (9) @(posedge CLK);
        #1;
        check("stats.miss.br", {16'd0, br_count}, 32'd11);
        check("stats.miss.miss", {16'd0, miss_count}, 32'd3);
        ex_taken = 0;
        repeat (66000) @(posedge CLK);
        #1;
        check("stats.sat.br", {16'd0, br_count}, 32'hFFFF);
        check("stats.sat.miss", {16'd0, miss_count}, 32'd3);
        nRST = 0;
        #1;
        check("stats.clr.br", {16'd0, br_count}, 32'd0);
        check("stats.clr.miss", {16'd0, miss_count}, 32'd0);
        @(negedge CLK); nRST = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
